alu_mul_sequencer: RTL

- Multi-cycle unsigned/two's-complement multiplier controller that owns one external Hack-style 16-bit ALU (zx/nx/zy/ny/f/no control word, zr/ng flags).
- Computes a product by shift-and-add. Every addition and every doubling is issued to the ALU as an x+y control word.
- Operands are accepted on a valid/ready input port; the low WIDTH bits of the product are returned on a valid/ready output port.
- Sits between the CPU-side operand registers and the shared ALU instance.

---
 rtl/alu_mul_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer
// Purpose  : Shift-and-add multiplier controller that drives one external
//            Hack-style ALU. Every partial-product addition and every
//            doubling of the multiplicand is issued to the ALU as an x+y
//            control word; the block itself contains no adder.
// Ports    : clk, rst_n           clock, asynchronous active-low reset
//            in_valid/in_ready    operand handshake (in_a multiplicand,
//                                 in_b multiplier)
//            out_valid/out_ready  product handshake (out_p = a*b mod 2^WIDTH,
//                                 out_zr / out_ng flags captured from the ALU)
//            alu_x, alu_y         ALU data operands
//            alu_zx..alu_no       ALU control word
//            alu_out, alu_zr/ng   combinational ALU result and flags
// Options  : ALU_MUL_EARLY_EXIT_EN - when defined, the iteration loop ends as
//            soon as no set multiplier bits remain.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_p,
    output logic             out_zr,
    output logic             out_ng,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng
);

    // A 1-bit counter keeps the degenerate WIDTH=1 build legal.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DBL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mc;
    logic [WIDTH-1:0] r_mr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_zr;
    logic             r_ng;

    logic             w_last;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_p     = r_acc;
    assign out_zr    = r_zr;
    assign out_ng    = r_ng;

    // Decides, during DBL, whether this was the final iteration.
`ifdef ALU_MUL_EARLY_EXIT_EN
    // Once the remaining multiplier bits are all zero, further iterations
    // would only add zero, so the loop can stop early.
    assign w_last = (r_cnt == c_cnt_last) || ((r_mr >> 1) == '0);
`else
    assign w_last = (r_cnt == c_cnt_last);
`endif

    // ALU control. Outside ADD/DBL the ALU is parked on the constant-0 word
    // so it never toggles on stale operands.
    always_comb begin
        alu_x  = '0;
        alu_y  = '0;
        alu_zx = 1'b1;
        alu_nx = 1'b0;
        alu_zy = 1'b1;
        alu_ny = 1'b0;
        alu_f  = 1'b1;
        alu_no = 1'b0;
        case (r_state)
            ADD: begin
                // acc + (mr[0] ? mc : 0): zeroing y implements the skip.
                alu_x  = r_acc;
                alu_y  = r_mc;
                alu_zx = 1'b0;
                alu_zy = ~r_mr[0];
            end
            DBL: begin
                // mc + mc doubles the multiplicand.
                alu_x  = r_mc;
                alu_y  = r_mc;
                alu_zx = 1'b0;
                alu_zy = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_mc    <= '0;
            r_mr    <= '0;
            r_cnt   <= '0;
            r_zr    <= 1'b0;
            r_ng    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_acc   <= '0;
                        r_mc    <= in_a;
                        r_mr    <= in_b;
                        r_cnt   <= '0;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    // The last ADD of the loop leaves the final product in
                    // acc, so its flags are the product's flags.
                    r_acc   <= alu_out;
                    r_zr    <= alu_zr;
                    r_ng    <= alu_ng;
                    r_state <= DBL;
                end
                DBL: begin
                    r_mc    <= alu_out;
                    r_mr    <= r_mr >> 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_state <= w_last ? DONE : ADD;
                end
                DONE: begin
                    // No accept here: a new operand waits for the IDLE cycle.
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
